// File: rtl/piso_shift_reg.sv
// piso_shift_reg: parallel-in/serial-out transmitter, MSB first, gapless back-to-back frames
module piso_shift_reg #(
  parameter int WIDTH = 2
) (
  input  logic             C,
  input  logic             R,
  input  logic [WIDTH-1:0] D,
  input  logic             LD,
  output logic             RDY,
  output logic             Q,
  output logic             nQ,
  output logic             BUSY,
  output logic             DONE
);
  localparam int CW = $clog2(WIDTH);
  if (WIDTH < 2) begin : g_bad_width
    $error("piso_shift_reg: WIDTH must be >= 2");
  end
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t           r_state, w_state_n;
  logic [WIDTH-1:0] r_shreg, w_shreg_n;
  logic [CW-1:0]    r_cnt, w_cnt_n;
  logic             r_q, w_q_n, r_done, w_done_n, w_last, w_load;
  assign w_last = (r_state == SHIFT) && (r_cnt == '0);
  assign RDY    = (r_state == IDLE) || (r_cnt == '0);
  assign w_load = LD && RDY;
  assign Q      = r_q;
  assign nQ     = ~r_q;
  assign BUSY   = (r_state == SHIFT);
  assign DONE   = r_done;
  always_comb begin
    w_state_n = r_state;
    w_shreg_n = r_shreg;
    w_cnt_n   = r_cnt;
    w_q_n     = r_q;
    w_done_n  = w_last;
    if (w_load) begin
      w_state_n = SHIFT;
      w_shreg_n = D;
      w_q_n     = D[WIDTH-1];
      w_cnt_n   = CW'(WIDTH - 1);
    end else if (w_last) begin
      w_state_n = IDLE;
      w_q_n     = 1'b0;
    end else if (r_state == SHIFT) begin
      w_shreg_n = r_shreg << 1;
      w_q_n     = r_shreg[WIDTH-2];
      w_cnt_n   = r_cnt - 1'b1;
    end
  end
  always_ff @(posedge C or posedge R) begin
    if (R) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
      r_q     <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_shreg <= w_shreg_n;
      r_cnt   <= w_cnt_n;
      r_q     <= w_q_n;
      r_done  <= w_done_n;
    end
  end
endmodule

// File: tb/tb_piso_shift_reg.sv
// tb_piso_shift_reg: directed checks of a WIDTH=2 and a WIDTH=4 transmitter plus a loopback receiver
module tb_piso_shift_reg;
  logic       C = 1'b0;
  logic       R, RB;
  logic [1:0] D;
  logic [3:0] DB;
  logic       LD, LDB;
  logic       RDY, Q, nQ, BUSY, DONE;
  logic       RDYB, QB, nQB, BUSYB, DONEB;
  logic       rx_q1, rx_q2;
  int         n_chk = 0, n_fail = 0;

  initial begin
    #10;
    forever #5 C = ~C;
  end

  piso_shift_reg #(.WIDTH(2)) dut2 (
    .C(C), .R(R), .D(D), .LD(LD), .RDY(RDY), .Q(Q), .nQ(nQ), .BUSY(BUSY), .DONE(DONE)
  );
  piso_shift_reg #(.WIDTH(4)) dut4 (
    .C(C), .R(RB), .D(DB), .LD(LDB), .RDY(RDYB), .Q(QB), .nQ(nQB), .BUSY(BUSYB), .DONE(DONEB)
  );

  // Stand-in for the downstream 2-bit serial-in shift register
  always_ff @(posedge C) begin
    rx_q1 <= Q;
    rx_q2 <= rx_q1;
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge C);
    #1;
  endtask

  task automatic chk2(input string tag, input logic q, input logic rdy, input logic busy, input logic done);
    chk({tag, ".Q"}, Q, q);
    chk({tag, ".nQ"}, nQ, ~q);
    chk({tag, ".RDY"}, RDY, rdy);
    chk({tag, ".BUSY"}, BUSY, busy);
    chk({tag, ".DONE"}, DONE, done);
  endtask

  task automatic chk4(input string tag, input logic q, input logic rdy, input logic busy, input logic done);
    chk({tag, ".Q"}, QB, q);
    chk({tag, ".nQ"}, nQB, ~q);
    chk({tag, ".RDY"}, RDYB, rdy);
    chk({tag, ".BUSY"}, BUSYB, busy);
    chk({tag, ".DONE"}, DONEB, done);
  endtask

  initial begin
    R = 1'b1; RB = 1'b1; D = '0; DB = '0; LD = 1'b0; LDB = 1'b0;
    #1;
    chk2("rst_held", 1'b0, 1'b1, 1'b0, 1'b0);
    chk4("rst_held4", 1'b0, 1'b1, 1'b0, 1'b0);
    #4 R = 1'b0; RB = 1'b0;
    #1;
    chk2("rst_rel", 1'b0, 1'b1, 1'b0, 1'b0);

    // single frame 2'b10
    D = 2'b10; LD = 1'b1;
    step(); LD = 1'b0;
    chk2("f1.b1", 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    chk2("f1.b0", 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    chk2("f1.end", 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    chk2("f1.idle", 1'b0, 1'b1, 1'b0, 1'b0);

    // streaming: 2'b10 then 2'b01 with LD held high
    D = 2'b10; LD = 1'b1;
    step(); D = 2'b01;
    chk2("s.a1", 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    chk2("s.a0", 1'b0, 1'b1, 1'b1, 1'b0);
    step(); LD = 1'b0;
    chk2("s.b1", 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    chk2("s.b0", 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    chk2("s.end", 1'b0, 1'b1, 1'b0, 1'b1);

    // load request while RDY=0 is ignored
    D = 2'b01; LD = 1'b1;
    step(); D = 2'b11;
    chk2("ign.b1", 1'b0, 1'b0, 1'b1, 1'b0);
    step(); LD = 1'b0;
    chk2("ign.b0", 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    chk2("ign.end", 1'b0, 1'b1, 1'b0, 1'b1);

    // loopback into the receiver
    D = 2'b10; LD = 1'b1;
    step(); LD = 1'b0;
    step();
    step();
    chk("lb.Q2", rx_q2, 1'b1);
    chk("lb.Q1", rx_q1, 1'b0);
    chk2("lb.end", 1'b0, 1'b1, 1'b0, 1'b1);

    // WIDTH=4: reset pulse mid-frame abandons it
    DB = 4'b1011; LDB = 1'b1;
    step(); LDB = 1'b0;
    chk4("w4.b3", 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    chk4("w4.b2", 1'b0, 1'b0, 1'b1, 1'b0);
    #2 RB = 1'b1;
    #1;
    chk4("w4.rst", 1'b0, 1'b1, 1'b0, 1'b0);
    #2 RB = 1'b0;
    step();
    chk4("w4.post", 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    chk4("w4.nodone", 1'b0, 1'b1, 1'b0, 1'b0);

    // WIDTH=4: clean frame 4'b0110 after the abort
    DB = 4'b0110; LDB = 1'b1;
    step(); LDB = 1'b0;
    chk4("w4n.b3", 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    chk4("w4n.b2", 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    chk4("w4n.b1", 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    chk4("w4n.b0", 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    chk4("w4n.end", 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    chk4("w4n.idle", 1'b0, 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
